// File: rtl/onchip_mem_dma_pkg.sv
// Shared types and default sizes for the on-chip memory DMA master.
package onchip_mem_dma_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MODE_FILL     = 2'd0,
        MODE_COPY     = 2'd1,
        MODE_CHECKSUM = 2'd2,
        MODE_ILLEGAL  = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_WR,
        S_CP_RD,
        S_CP_CAP,
        S_CP_WR,
        S_CK_RD,
        S_CK_DRAIN,
        S_FIN
    } state_t;

endpackage

// File: rtl/onchip_mem_dma_master.sv
// Avalon-MM fixed-latency master: one FILL, COPY or CHECKSUM command at a time
// on the second port of the on-chip memory. All outputs come from registers.
module onchip_mem_dma_master #(
    parameter int ADDR_W = onchip_mem_dma_pkg::ADDR_W,
    parameter int DATA_W = onchip_mem_dma_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [ADDR_W-1:0]     cmd_src,
    input  logic [ADDR_W-1:0]     cmd_dst,
    input  logic [ADDR_W:0]       cmd_len,
    input  logic [DATA_W-1:0]     cmd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_W-1:0]     result,
    output logic [ADDR_W-1:0]     address,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     readdata
);
    import onchip_mem_dma_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    state_t              state, state_n;
    mode_t               mode;
    logic [ADDR_W-1:0]   src, src_n, dst, dst_n;
    logic [CNT_W-1:0]    count, count_n;
    logic [DATA_W-1:0]   fill, fill_n;
    logic [DATA_W-1:0]   result_q, result_n, wdata_q, wdata_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                error_q, error_n, busy_q, busy_n, ready_q, ready_n;
    logic                done_q, done_n, cs_q, cs_n, wr_q, wr_n;
    logic                pending_q, pending_n;

    assign mode = mode_t'(cmd_mode);

    always_comb begin
        state_n   = state;
        src_n     = src;
        dst_n     = dst;
        count_n   = count;
        fill_n    = fill;
        result_n  = result_q;
        error_n   = error_q;
        busy_n    = busy_q;
        ready_n   = ready_q;
        done_n    = 1'b0;
        cs_n      = 1'b0;
        wr_n      = 1'b0;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        // A checksum read issued last cycle has its data on readdata now.
        pending_n = (state == S_CK_RD);
        if (pending_q) result_n = result_q + readdata;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_n    = cmd_src;
                    dst_n    = cmd_dst;
                    count_n  = cmd_len;
                    fill_n   = cmd_data;
                    result_n = '0;
                    error_n  = 1'b0;
                    busy_n   = 1'b1;
                    ready_n  = 1'b0;
                    if (cmd_len == '0 || mode == MODE_ILLEGAL) begin
                        state_n = S_FIN;
                        done_n  = 1'b1;
                        error_n = (mode == MODE_ILLEGAL);
                    end else begin
                        count_n = cmd_len - CNT_W'(1);
                        cs_n    = 1'b1;
                        case (mode)
                            MODE_FILL: begin
                                state_n = S_FILL_WR;
                                wr_n    = 1'b1;
                                addr_n  = cmd_dst;
                                wdata_n = cmd_data;
                                dst_n   = cmd_dst + ADDR_W'(1);
                            end
                            MODE_COPY: begin
                                state_n = S_CP_RD;
                                addr_n  = cmd_src;
                                src_n   = cmd_src + ADDR_W'(1);
                            end
                            default: begin
                                state_n = S_CK_RD;
                                addr_n  = cmd_src;
                                src_n   = cmd_src + ADDR_W'(1);
                            end
                        endcase
                    end
                end
            end
            S_FILL_WR: begin
                if (count == '0) begin
                    state_n = S_FIN;
                    done_n  = 1'b1;
                end else begin
                    cs_n    = 1'b1;
                    wr_n    = 1'b1;
                    addr_n  = dst;
                    wdata_n = fill;
                    dst_n   = dst + ADDR_W'(1);
                    count_n = count - CNT_W'(1);
                end
            end
            S_CP_RD: state_n = S_CP_CAP;
            S_CP_CAP: begin
                // The writedata register doubles as the copy buffer.
                state_n = S_CP_WR;
                cs_n    = 1'b1;
                wr_n    = 1'b1;
                addr_n  = dst;
                wdata_n = readdata;
                dst_n   = dst + ADDR_W'(1);
            end
            S_CP_WR: begin
                if (count == '0) begin
                    state_n = S_FIN;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_CP_RD;
                    cs_n    = 1'b1;
                    addr_n  = src;
                    src_n   = src + ADDR_W'(1);
                    count_n = count - CNT_W'(1);
                end
            end
            S_CK_RD: begin
                if (count == '0) begin
                    state_n = S_CK_DRAIN;
                end else begin
                    cs_n    = 1'b1;
                    addr_n  = src;
                    src_n   = src + ADDR_W'(1);
                    count_n = count - CNT_W'(1);
                end
            end
            S_CK_DRAIN: begin
                state_n = S_FIN;
                done_n  = 1'b1;
            end
            S_FIN: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                ready_n = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            src       <= '0;
            dst       <= '0;
            count     <= '0;
            fill      <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state     <= state_n;
            src       <= src_n;
            dst       <= dst_n;
            count     <= count_n;
            fill      <= fill_n;
            result_q  <= result_n;
            error_q   <= error_n;
            busy_q    <= busy_n;
            ready_q   <= ready_n;
            done_q    <= done_n;
            cs_q      <= cs_n;
            wr_q      <= wr_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            pending_q <= pending_n;
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign result     = result_q;
    assign address    = addr_q;
    assign chipselect = cs_q;
    assign write      = wr_q;
    assign writedata  = wdata_q;
    assign byteenable = '1;

endmodule

// File: tb/tb_onchip_mem_dma_master.sv
// Scoreboard bench for onchip_mem_dma_master with a 1-cycle-latency RAM model;
// expected bus cycles and completions are queued at issue and checked by a monitor.
module tb_onchip_mem_dma_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = '0;
    logic [9:0]  cmd_src = '0;
    logic [9:0]  cmd_dst = '0;
    logic [10:0] cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        busy, done, error;
    logic [31:0] result;
    logic [9:0]  address;
    logic        chipselect, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    logic [31:0] mem [1024];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int unsigned edges = 0;
    int unsigned t_acc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int unsigned off;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        int unsigned off;
        logic [31:0] res;
        logic        err;
    } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];
    bus_t  mb;
    done_t md;

    onchip_mem_dma_master #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .busy(busy), .done(done), .error(error), .result(result),
        .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edges <= edges + 1;
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (chipselect && write) mem[address] <= writedata;
        if (chipselect && !write) readdata <= mem[address];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none (t=%0t)", name, act, $time);
    endtask

    // Monitor: every bus cycle and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (chipselect) begin
            if (bus_q.size() == 0) begin
                flag("bus_unexpected", {22'd0, write, address, writedata});
            end else begin
                mb = bus_q.pop_front();
                chk("bus_offset", edges - t_acc, mb.off);
                chk("bus_write", write, mb.wr);
                chk("bus_address", address, mb.addr);
                chk("bus_byteenable", byteenable, 4'hF);
                if (mb.wr) chk("bus_writedata", writedata, mb.data);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                flag("done_unexpected", edges - t_acc);
            end else begin
                md = done_q.pop_front();
                chk("done_offset", edges - t_acc, md.off);
                chk("done_result", result, md.res);
                chk("done_error", error, md.err);
                chk("done_busy", busy, 1'b1);
            end
        end
    end

    task automatic push_bus(input int unsigned off, input logic wr, input logic [9:0] addr,
                            input logic [31:0] data);
        bus_t b;
        b.off = off; b.wr = wr; b.addr = addr; b.data = data;
        bus_q.push_back(b);
    endtask

    task automatic push_done(input int unsigned off, input logic [31:0] res, input logic err);
        done_t d;
        d.off = off; d.res = res; d.err = err;
        done_q.push_back(d);
    endtask

    task automatic poke(input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Returns at the negedge of cycle T+1.
    task automatic issue(input logic [1:0] mode, input logic [9:0] src, input logic [9:0] dst,
                         input logic [10:0] len, input logic [31:0] data);
        int unsigned n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_issue", cmd_ready, 1'b1);
        cmd_mode = mode; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_data = data;
        cmd_valid = 1'b1;
        t_acc = edges;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned n = 0;
        while ((done_q.size() != 0 || bus_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_q.size() != 0 || bus_q.size() != 0) begin
            flag({name, "_timeout"}, done_q.size() + bus_q.size());
            done_q.delete();
            bus_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_chipselect", chipselect, 1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_address", address, 10'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_byteenable", byteenable, 4'hF);

        // Preload mem[i] = i through the model's back door.
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 10'(i); pre_data = 32'(i);
        end
        @(negedge clk);
        pre_we = 1'b0;

        // CHECKSUM over the whole memory: sum 0..1023 = 0x7FE00.
        for (int i = 0; i < 1024; i++) push_bus(32'(i + 1), 1'b0, 10'(i), 32'h0);
        push_done(1026, 32'h0007_FE00, 1'b0);
        issue(2'd2, 10'h000, 10'h000, 11'd1024, 32'h0);
        wait_done("checksum", 1100);

        // FILL wrapping past the top of memory; result cleared by the accept.
        push_bus(1, 1'b1, 10'h3FE, 32'hA5A5_0001);
        push_bus(2, 1'b1, 10'h3FF, 32'hA5A5_0001);
        push_bus(3, 1'b1, 10'h000, 32'hA5A5_0001);
        push_bus(4, 1'b1, 10'h001, 32'hA5A5_0001);
        push_done(5, 32'h0, 1'b0);
        issue(2'd0, 10'h000, 10'h3FE, 11'd4, 32'hA5A5_0001);
        wait_done("fill", 40);
        chk("fill_mem_3fd", mem[10'h3FD], 32'h3FD);
        chk("fill_mem_002", mem[10'h002], 32'h2);

        // COPY 0x010..0x012 -> 0x100..0x102; CAP cycles leave the bus idle.
        poke(10'h010, 32'd1);
        poke(10'h011, 32'd2);
        poke(10'h012, 32'd3);
        push_bus(1, 1'b0, 10'h010, 32'h0);
        push_bus(3, 1'b1, 10'h100, 32'd1);
        push_bus(4, 1'b0, 10'h011, 32'h0);
        push_bus(6, 1'b1, 10'h101, 32'd2);
        push_bus(7, 1'b0, 10'h012, 32'h0);
        push_bus(9, 1'b1, 10'h102, 32'd3);
        push_done(10, 32'h0, 1'b0);
        issue(2'd1, 10'h010, 10'h100, 11'd3, 32'h0);
        wait_done("copy", 40);
        chk("copy_mem_100", mem[10'h100], 32'd1);
        chk("copy_mem_101", mem[10'h101], 32'd2);
        chk("copy_mem_102", mem[10'h102], 32'd3);
        chk("copy_mem_103", mem[10'h103], 32'h103);

        // Overlapping COPY replicates the first source word.
        poke(10'h000, 32'd7);
        poke(10'h001, 32'd8);
        poke(10'h002, 32'd9);
        poke(10'h003, 32'd10);
        push_bus(1, 1'b0, 10'h000, 32'h0);
        push_bus(3, 1'b1, 10'h001, 32'd7);
        push_bus(4, 1'b0, 10'h001, 32'h0);
        push_bus(6, 1'b1, 10'h002, 32'd7);
        push_bus(7, 1'b0, 10'h002, 32'h0);
        push_bus(9, 1'b1, 10'h003, 32'd7);
        push_done(10, 32'h0, 1'b0);
        issue(2'd1, 10'h000, 10'h001, 11'd3, 32'h0);
        wait_done("overlap", 40);
        chk("overlap_mem_1", mem[10'h001], 32'd7);
        chk("overlap_mem_2", mem[10'h002], 32'd7);
        chk("overlap_mem_3", mem[10'h003], 32'd7);

        // len 0: immediate done, no bus activity.
        push_done(1, 32'h0, 1'b0);
        issue(2'd0, 10'h000, 10'h050, 11'd0, 32'hFFFF_FFFF);
        wait_done("len0", 20);

        // Illegal mode: immediate done with sticky error, cleared on next accept.
        push_done(1, 32'h0, 1'b1);
        issue(2'd3, 10'h000, 10'h050, 11'd5, 32'hFFFF_FFFF);
        wait_done("mode3", 20);
        repeat (2) @(negedge clk);
        chk("mode3_error_sticky", error, 1'b1);
        chk("mode3_busy_after", busy, 1'b0);
        push_done(1, 32'h0, 1'b0);
        issue(2'd0, 10'h000, 10'h050, 11'd0, 32'h0);
        wait_done("error_clear", 20);
        chk("mem_050_untouched", mem[10'h050], 32'h50);

        // Reset during FILL len 8: only the first word lands, no done pulse.
        push_bus(1, 1'b1, 10'h200, 32'hDEAD_0000);
        issue(2'd0, 10'h000, 10'h200, 11'd8, 32'hDEAD_0000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_chipselect", chipselect, 1'b0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_address", address, 10'h0);
        repeat (12) @(negedge clk);
        chk("midrst_bus_pending", bus_q.size(), 0);
        chk("midrst_mem_200", mem[10'h200], 32'hDEAD_0000);
        chk("midrst_mem_201", mem[10'h201], 32'h201);
        chk("midrst_done", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
